// File: rtl/oam_dma_sink.sv
// ============================================================================
// Module   : oam_dma_sink
// Purpose  : OAM DMA responder and 160-byte OAM array with DMA > PPU > CPU access.
//            Optional build macro OAM_DMA_ERR_EN adds the sticky dma_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oam_dma_sink #(
    parameter int OAM_BYTES   = 160,
    parameter int ENTRY_BYTES = 4
) (
    input  logic        clk1,
    input  logic        nreset6,
    input  logic        dma_run,
    input  logic        dma_wr,
    input  logic [7:0]  dma_a,
    input  logic [7:0]  dma_d,
    output logic        dma_ack,
    output logic        dma_done,
    input  logic        ppu_rd,
    input  logic [5:0]  ppu_idx,
    output logic [31:0] ppu_q,
    output logic        ppu_qv,
    input  logic        cpu_sel,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_a,
    input  logic [7:0]  cpu_din,
`ifdef OAM_DMA_ERR_EN
    output logic        dma_err,
`endif
    output logic [7:0]  cpu_dout
);

    localparam logic [7:0] LAST_ADDR = 8'(OAM_BYTES - 1);
    localparam logic [5:0] LAST_IDX  = 6'(OAM_BYTES / ENTRY_BYTES - 1);

    logic [7:0]  mem [OAM_BYTES];

    logic        pend_v;
    logic [7:0]  pend_a;
    logic [7:0]  pend_d;
    logic [7:0]  count;

    logic        dma_beat;
    logic        beat_ok;
    logic        last_commit;
    logic        cpu_ok;
    logic        cpu_wr_en;
    logic [7:0]  entry_base;
    logic [31:0] entry;

    always_comb begin
        dma_beat    = dma_run & dma_wr;
        beat_ok     = dma_beat && (dma_a <= LAST_ADDR);
        last_commit = pend_v && (pend_a == LAST_ADDR);
        cpu_ok      = cpu_sel && !dma_run && (cpu_a <= LAST_ADDR);
        // A committing DMA beat owns the write port; a colliding CPU write is lost.
        cpu_wr_en   = cpu_ok && cpu_wr && !pend_v;
        entry_base  = {ppu_idx, 2'b00};
        entry       = {mem[entry_base + 8'd3], mem[entry_base + 8'd2],
                       mem[entry_base + 8'd1], mem[entry_base]};
    end

    // OAM storage is intentionally outside the reset domain.
    always_ff @(posedge clk1) begin
        if (pend_v) begin
            mem[pend_a] <= pend_d;
        end else if (cpu_wr_en) begin
            mem[cpu_a] <= cpu_din;
        end
    end

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            pend_v   <= 1'b0;
            pend_a   <= 8'h00;
            pend_d   <= 8'h00;
            dma_ack  <= 1'b0;
            dma_done <= 1'b0;
            count    <= 8'h00;
            ppu_q    <= 32'hFFFF_FFFF;
            ppu_qv   <= 1'b0;
            cpu_dout <= 8'hFF;
        end else begin
            pend_v   <= beat_ok;
            if (beat_ok) begin
                pend_a <= dma_a;
                pend_d <= dma_d;
            end
            dma_ack  <= pend_v;
            dma_done <= last_commit;

            if (!dma_run || last_commit) begin
                count <= 8'h00;
            end else if (pend_v) begin
                count <= count + 8'd1;
            end

            ppu_qv <= ppu_rd;
            if (ppu_rd) begin
                ppu_q <= (dma_run || (ppu_idx > LAST_IDX)) ? 32'hFFFF_FFFF : entry;
            end

            if (cpu_sel && cpu_rd) begin
                cpu_dout <= cpu_ok ? mem[cpu_a] : 8'hFF;
            end
        end
    end

`ifdef OAM_DMA_ERR_EN
    logic       run_q;
    logic [7:0] expect_a;

    // The beat in flight has not yet advanced count, so account for it here.
    always_comb begin
        if (pend_v) begin
            expect_a = (pend_a == LAST_ADDR) ? 8'h00 : count + 8'd1;
        end else begin
            expect_a = count;
        end
    end

    always_ff @(posedge clk1 or negedge nreset6) begin
        if (!nreset6) begin
            run_q   <= 1'b0;
            dma_err <= 1'b0;
        end else begin
            run_q <= dma_run;
            if (dma_beat && ((dma_a > LAST_ADDR) || (dma_a != expect_a))) begin
                dma_err <= 1'b1;
            end else if (dma_run && !run_q) begin
                dma_err <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_sink.sv
// Directed self-checking bench for oam_dma_sink.
`default_nettype none

module tb_oam_dma_sink;

    logic        clk1 = 1'b0;
    logic        nreset6 = 1'b0;
    logic        dma_run = 1'b0;
    logic        dma_wr = 1'b0;
    logic [7:0]  dma_a = 8'h00;
    logic [7:0]  dma_d = 8'h00;
    logic        dma_ack;
    logic        dma_done;
    logic        ppu_rd = 1'b0;
    logic [5:0]  ppu_idx = 6'd0;
    logic [31:0] ppu_q;
    logic        ppu_qv;
    logic        cpu_sel = 1'b0;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_a = 8'h00;
    logic [7:0]  cpu_din = 8'h00;
    logic [7:0]  cpu_dout;
`ifdef OAM_DMA_ERR_EN
    logic        dma_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    oam_dma_sink dut (
        .clk1(clk1), .nreset6(nreset6),
        .dma_run(dma_run), .dma_wr(dma_wr), .dma_a(dma_a), .dma_d(dma_d),
        .dma_ack(dma_ack), .dma_done(dma_done),
        .ppu_rd(ppu_rd), .ppu_idx(ppu_idx), .ppu_q(ppu_q), .ppu_qv(ppu_qv),
        .cpu_sel(cpu_sel), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a),
        .cpu_din(cpu_din),
`ifdef OAM_DMA_ERR_EN
        .dma_err(dma_err),
`endif
        .cpu_dout(cpu_dout)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] v);
        cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_a = a;
        tick();
        cpu_sel = 1'b0; cpu_rd = 1'b0;
        v = cpu_dout;
    endtask

    task automatic test_reset();
        nreset6 = 1'b0;
        tick(); tick();
        n_cmp++;
        if (dma_ack !== 1'b0 || dma_done !== 1'b0 || ppu_qv !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ack=%b done=%b qv=%b want 0 0 0", dma_ack, dma_done, ppu_qv);
        end
        n_cmp++;
        if (ppu_q !== 32'hFFFF_FFFF || cpu_dout !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_data: got ppu_q=%h cpu_dout=%h want ffffffff ff", ppu_q, cpu_dout);
        end
        nreset6 = 1'b1;
        tick();
    endtask

    task automatic test_dma_ignore();
        int acks = 0;
        dma_run = 1'b0; dma_wr = 1'b1; dma_a = 8'd5; dma_d = 8'h11;
        tick(); acks += int'(dma_ack);
        dma_wr = 1'b0;
        tick(); acks += int'(dma_ack);
        dma_run = 1'b1; dma_wr = 1'b1; dma_a = 8'hA0;
        tick(); acks += int'(dma_ack);
        dma_wr = 1'b0;
        tick(); acks += int'(dma_ack);
        tick(); acks += int'(dma_ack);
        dma_run = 1'b0;
        tick();
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL ignored_beats: got %0d acks want 0", acks);
        end
    endtask

    task automatic test_full_transfer();
        int acks = 0;
        int dones = 0;
        logic [31:0] exp_q;
        dma_run = 1'b1;
        for (int i = 0; i < 160; i++) begin
            dma_wr = 1'b1; dma_a = 8'(i); dma_d = 8'(i) ^ 8'h5A;
            tick();
            acks += int'(dma_ack); dones += int'(dma_done);
        end
        dma_wr = 1'b0;
        tick();
        n_cmp++;
        if (dma_ack !== 1'b1 || dma_done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_with_last: got ack=%b done=%b want 1 1", dma_ack, dma_done);
        end
        acks += int'(dma_ack); dones += int'(dma_done);
        tick();
        acks += int'(dma_ack); dones += int'(dma_done);
        n_cmp++;
        if (acks != 160 || dones != 1) begin
            n_bad++;
            $display("FAIL full_counts: got acks=%0d dones=%0d want 160 1", acks, dones);
        end
        dma_run = 1'b0;
        tick();
        // Entry 2 covers bytes 8..11, each holding addr^5A.
        exp_q = 32'h5150_5352;
        ppu_rd = 1'b1; ppu_idx = 6'd2;
        tick();
        ppu_rd = 1'b0;
        n_cmp++;
        if (ppu_qv !== 1'b1 || ppu_q !== exp_q) begin
            n_bad++;
            $display("FAIL ppu_entry2: got qv=%b q=%h want 1 %h", ppu_qv, ppu_q, exp_q);
        end
        tick();
        n_cmp++;
        if (ppu_qv !== 1'b0) begin
            n_bad++;
            $display("FAIL ppu_qv_pulse: got %b want 0", ppu_qv);
        end
    endtask

    task automatic test_cpu_access();
        logic [7:0] v;
        dma_run = 1'b1;
        cpu_read(8'h10, v);
        n_cmp++;
        if (v !== 8'hFF) begin
            n_bad++;
            $display("FAIL cpu_rd_during_dma: got %h want ff", v);
        end
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h10; cpu_din = 8'h33;
        tick();
        cpu_sel = 1'b0; cpu_wr = 1'b0;
        dma_run = 1'b0;
        tick();
        cpu_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h4A) begin
            n_bad++;
            $display("FAIL cpu_wr_dropped: got %h want 4a", v);
        end
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h10; cpu_din = 8'h33;
        tick();
        cpu_sel = 1'b0; cpu_wr = 1'b0;
        cpu_read(8'h10, v);
        n_cmp++;
        if (v !== 8'h33) begin
            n_bad++;
            $display("FAIL cpu_wr_idle: got %h want 33", v);
        end
        tick();
        n_cmp++;
        if (cpu_dout !== 8'h33) begin
            n_bad++;
            $display("FAIL cpu_dout_hold: got %h want 33", cpu_dout);
        end
        cpu_read(8'hA0, v);
        n_cmp++;
        if (v !== 8'hFF) begin
            n_bad++;
            $display("FAIL cpu_rd_range: got %h want ff", v);
        end
    endtask

    task automatic test_ppu_blocked();
        dma_run = 1'b1;
        ppu_rd = 1'b1; ppu_idx = 6'd5;
        tick();
        ppu_rd = 1'b0; dma_run = 1'b0;
        n_cmp++;
        if (ppu_qv !== 1'b1 || ppu_q !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL ppu_during_dma: got qv=%b q=%h want 1 ffffffff", ppu_qv, ppu_q);
        end
        ppu_rd = 1'b1; ppu_idx = 6'd0;
        tick();
        n_cmp++;
        if (ppu_q !== 32'h5958_5B5A) begin
            n_bad++;
            $display("FAIL ppu_entry0: got %h want 59585b5a", ppu_q);
        end
        ppu_idx = 6'd40;
        tick();
        ppu_rd = 1'b0;
        n_cmp++;
        if (ppu_qv !== 1'b1 || ppu_q !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL ppu_idx_range: got qv=%b q=%h want 1 ffffffff", ppu_qv, ppu_q);
        end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        int acks = 0;
        int dones = 0;
        logic [7:0] v;
        dma_run = 1'b1;
        for (int i = 0; i <= 81; i++) begin
            dma_wr = 1'b1; dma_a = 8'(i); dma_d = 8'(i) ^ 8'hA5;
            tick();
            acks += int'(dma_ack); dones += int'(dma_done);
        end
        nreset6 = 1'b0;
        #1;
        n_cmp++;
        if (dma_ack !== 1'b0 || dma_done !== 1'b0 || ppu_qv !== 1'b0 ||
            ppu_q !== 32'hFFFF_FFFF || cpu_dout !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_mid: got ack=%b done=%b qv=%b q=%h dout=%h want 0 0 0 ffffffff ff",
                     dma_ack, dma_done, ppu_qv, ppu_q, cpu_dout);
        end
        dma_wr = 1'b0; dma_run = 1'b0;
        tick(); tick();
        nreset6 = 1'b1;
        tick();
        acks += int'(dma_ack); dones += int'(dma_done);
        tick();
        acks += int'(dma_ack); dones += int'(dma_done);
        n_cmp++;
        if (acks != 81 || dones != 0) begin
            n_bad++;
            $display("FAIL reset_mid_counts: got acks=%0d dones=%0d want 81 0", acks, dones);
        end
        cpu_read(8'd0, v);
        n_cmp++;
        if (v !== 8'hA5) begin
            n_bad++;
            $display("FAIL retain_byte0: got %h want a5", v);
        end
        cpu_read(8'd80, v);
        n_cmp++;
        if (v !== 8'hF5) begin
            n_bad++;
            $display("FAIL retain_byte80: got %h want f5", v);
        end
        cpu_read(8'd81, v);
        n_cmp++;
        if (v !== 8'h0B) begin
            n_bad++;
            $display("FAIL discard_byte81: got %h want 0b", v);
        end
    endtask

    task automatic test_abort_and_restart();
        int dones = 0;
        dma_run = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            dma_wr = 1'b1; dma_a = 8'(i); dma_d = 8'(i) ^ 8'h5A;
            tick();
            dones += int'(dma_done);
        end
        dma_wr = 1'b0; dma_run = 1'b0;
        tick();
        n_cmp++;
        if (dma_ack !== 1'b1 || dma_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_last_ack: got ack=%b done=%b want 1 0", dma_ack, dma_done);
        end
        dones += int'(dma_done);
        tick();
        dones += int'(dma_done);
        dma_run = 1'b1;
        for (int i = 0; i < 160; i++) begin
            dma_wr = 1'b1; dma_a = 8'(i); dma_d = 8'(i) ^ 8'h5A;
            tick();
            dones += int'(dma_done);
        end
        dma_wr = 1'b0;
        tick(); dones += int'(dma_done);
        tick(); dones += int'(dma_done);
        dma_run = 1'b0;
        tick(); dones += int'(dma_done);
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL restart_done: got %0d dones want 1", dones);
        end
    endtask

    task automatic test_cpu_ppu_collision();
        cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'd8; cpu_din = 8'h77;
        ppu_rd = 1'b1; ppu_idx = 6'd2;
        tick();
        cpu_sel = 1'b0; cpu_wr = 1'b0;
        n_cmp++;
        if (ppu_q !== 32'h5150_5352) begin
            n_bad++;
            $display("FAIL collide_prewrite: got %h want 51505352", ppu_q);
        end
        tick();
        ppu_rd = 1'b0;
        n_cmp++;
        if (ppu_q !== 32'h5150_5377) begin
            n_bad++;
            $display("FAIL collide_postwrite: got %h want 51505377", ppu_q);
        end
        tick();
    endtask

`ifdef OAM_DMA_ERR_EN
    task automatic test_seq_err();
        dma_run = 1'b1;
        dma_wr = 1'b1; dma_a = 8'd0; dma_d = 8'h01;
        tick();
        dma_a = 8'd1;
        tick();
        n_cmp++;
        if (dma_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_in_sequence: got %b want 0", dma_err);
        end
        dma_a = 8'd3;
        tick();
        dma_wr = 1'b0;
        tick();
        n_cmp++;
        if (dma_ack !== 1'b1 || dma_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_skip: got ack=%b err=%b want 1 1", dma_ack, dma_err);
        end
        dma_run = 1'b0;
        tick();
        dma_run = 1'b1;
        tick();
        n_cmp++;
        if (dma_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got %b want 0", dma_err);
        end
        dma_run = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_dma_ignore();
        test_full_transfer();
        test_cpu_access();
        test_ppu_blocked();
        test_reset_mid_transfer();
        test_abort_and_restart();
        test_cpu_ppu_collision();
`ifdef OAM_DMA_ERR_EN
        test_seq_err();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
